// File: rtl/clock_ctrl.sv
// Sequencing controller for the DE0 hour clock: 1 Hz prescaler, push-button
// synchronise/debounce, RUN/SET_HOUR/SET_MIN mode FSM and counter enables.
module clock_ctrl #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HOUR = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;

    logic [PW-1:0]        prescaler_r;
    logic                 tick_s;
    // Bit 0 is the mode button, bit 1 the increment button.
    logic [1:0]           sync1_r;
    logic [1:0]           sync2_r;
    logic [1:0]           stable_r;
    logic [1:0]           stable_d_r;
    logic [1:0][DW-1:0]   db_cnt_r;
    logic [1:0]           press_s;
    logic                 mode_press_s;
    logic                 inc_press_s;
    logic                 leave_set_s;

    logic [1:0]           mode_r;
    logic [1:0]           mode_next_s;
    logic                 sec_en_r,  sec_en_s;
    logic                 min_en_r,  min_en_s;
    logic                 hour_en_r, hour_en_s;
    logic                 sec_clr_r;
    logic                 blink_r,   blink_s;

    assign tick_s       = (prescaler_r == PRE_LAST);
    assign press_s      = stable_d_r & ~stable_r;
    assign mode_press_s = press_s[0];
    // A simultaneous mode press wins; the increment is dropped.
    assign inc_press_s  = press_s[1] & ~press_s[0];
    assign leave_set_s  = (mode_r == SET_MIN) & mode_press_s;

    // Free-running 1 Hz prescaler, restarted when leaving the set modes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescaler_r <= '0;
        end else if (leave_set_s || tick_s) begin
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    // Two-stage synchroniser and stable-level debounce for both buttons.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_r    <= 2'b11;
            sync2_r    <= 2'b11;
            stable_r   <= 2'b11;
            stable_d_r <= 2'b11;
            db_cnt_r   <= '0;
        end else begin
            sync1_r    <= {btn_inc, btn_mode};
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != stable_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        stable_r[i] <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Next mode and the enable/blink values to register this cycle.
    always_comb begin
        mode_next_s = mode_r;
        sec_en_s    = 1'b0;
        min_en_s    = 1'b0;
        hour_en_s   = 1'b0;
        blink_s     = 1'b1;
        case (mode_r)
            RUN: begin
                mode_next_s = mode_press_s ? SET_HOUR : RUN;
                sec_en_s    = tick_s;
                min_en_s    = tick_s & sec_carry;
                hour_en_s   = tick_s & sec_carry & min_carry;
                blink_s     = 1'b1;
            end
            SET_HOUR: begin
                mode_next_s = mode_press_s ? SET_MIN : SET_HOUR;
                hour_en_s   = inc_press_s;
                blink_s     = (prescaler_r < PRE_HALF);
            end
            SET_MIN: begin
                mode_next_s = mode_press_s ? RUN : SET_MIN;
                min_en_s    = inc_press_s;
                blink_s     = (prescaler_r < PRE_HALF);
            end
            default: begin
                mode_next_s = RUN;
                blink_s     = 1'b1;
            end
        endcase
    end

    // Registered mode and output pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_r    <= RUN;
            sec_en_r  <= 1'b0;
            min_en_r  <= 1'b0;
            hour_en_r <= 1'b0;
            sec_clr_r <= 1'b0;
            blink_r   <= 1'b1;
        end else begin
            mode_r    <= mode_next_s;
            sec_en_r  <= sec_en_s;
            min_en_r  <= min_en_s;
            hour_en_r <= hour_en_s;
            sec_clr_r <= leave_set_s;
            blink_r   <= blink_s;
        end
    end

    assign sec_en  = sec_en_r;
    assign min_en  = min_en_r;
    assign hour_en = hour_en_r;
    assign sec_clr = sec_clr_r;
    assign mode    = mode_r;
    assign blink   = blink_r;

endmodule
